// File: rtl/seg_bcd_counter_if.sv
// Control and display bus of the BCD counter. The master drives the controls
// and the load value. The slave (the counter) drives the count, segments and strobes.
interface seg_bcd_counter_if #(
    parameter int unsigned DIGITS = 6
);
    logic                  en;
    logic                  up_dn;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   bcd;
    logic [7*DIGITS-1:0]   seg;
    logic                  tick;
    logic                  wrap;

    modport master (
        output en, up_dn, clear, load, load_val,
        input  bcd, seg, tick, wrap
    );

    modport slave (
        input  en, up_dn, clear, load, load_val,
        output bcd, seg, tick, wrap
    );
endinterface

// File: rtl/seg_bcd_counter.sv
// Multi-digit BCD up/down counter with a tick prescaler and a programmable wrap limit.
// It drives registered active-low seven-segment outputs with optional leading-zero blanking.
module seg_bcd_counter #(
    parameter int unsigned         TICK_DIV = 25000000,
    parameter int unsigned         DIGITS   = 6,
    parameter logic [4*DIGITS-1:0] MAX_BCD  = 24'h999999,
    parameter bit                  BLANK_LZ = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seg_bcd_counter_if.slave   bus
);
    localparam logic [31:0] PCNT_LAST = 32'(TICK_DIV - 1);

    logic [31:0]         pcnt_q, pcnt_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [7*DIGITS-1:0] seg_q, seg_d, seg_rst;
    logic                tick_q, tick_d;
    logic                wrap_q, wrap_d;

    logic [4*DIGITS-1:0] load_sat;
    logic [4*DIGITS-1:0] bcd_inc, bcd_dec;
    logic [DIGITS-1:0]   blank_d;
    logic                step;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign step = bus.en && (pcnt_q == PCNT_LAST);

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign load_sat[4*gi +: 4] = (bus.load_val[4*gi +: 4] > 4'd9) ? 4'd9 : bus.load_val[4*gi +: 4];
            assign seg_d[7*gi +: 7]    = blank_d[gi] ? 7'b1111111 : seg7(bcd_d[4*gi +: 4]);
            assign seg_rst[7*gi +: 7]  = ((gi > 0) && BLANK_LZ) ? 7'b1111111 : 7'b1000000;
        end
    endgenerate

    // Ripple carry/borrow across the digits: a digit only moves if every lower digit rolled over.
    always_comb begin
        logic c;
        logic b;
        c       = 1'b1;
        b       = 1'b1;
        bcd_inc = bcd_q;
        bcd_dec = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) bcd_inc[4*i +: 4] = (bcd_q[4*i +: 4] == 4'd9) ? 4'd0 : bcd_q[4*i +: 4] + 4'd1;
            if (b) bcd_dec[4*i +: 4] = (bcd_q[4*i +: 4] == 4'd0) ? 4'd9 : bcd_q[4*i +: 4] - 4'd1;
            c = c && (bcd_q[4*i +: 4] == 4'd9);
            b = b && (bcd_q[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        pcnt_d = pcnt_q;
        bcd_d  = bcd_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (bus.clear) begin
            pcnt_d = '0;
            bcd_d  = '0;
        end else if (bus.load) begin
            pcnt_d = '0;
            // Nibbles are already clamped to 9, so a plain unsigned compare orders BCD values.
            bcd_d  = (load_sat > MAX_BCD) ? MAX_BCD : load_sat;
        end else if (step) begin
            pcnt_d = '0;
            tick_d = 1'b1;
            if (bus.up_dn) begin
                if (bcd_q == MAX_BCD) begin
                    bcd_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    bcd_d  = bcd_inc;
                end
            end else begin
                if (bcd_q == '0) begin
                    bcd_d  = MAX_BCD;
                    wrap_d = 1'b1;
                end else begin
                    bcd_d  = bcd_dec;
                end
            end
        end else if (bus.en) begin
            pcnt_d = pcnt_q + 32'd1;
        end
    end

    always_comb begin
        logic hz;
        hz      = 1'b1;
        blank_d = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hz         = hz && (bcd_d[4*i +: 4] == 4'd0);
            blank_d[i] = BLANK_LZ && (i > 0) && hz;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
            bcd_q  <= '0;
            seg_q  <= seg_rst;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            bcd_q  <= bcd_d;
            seg_q  <= seg_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.bcd  = bcd_q;
    assign bus.seg  = seg_q;
    assign bus.tick = tick_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_seg_bcd_counter.sv
// Randomised bench for seg_bcd_counter: two configurations are checked every cycle
// against a decimal-arithmetic model, plus hand-computed directed expectations.
module tb_seg_bcd_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   armed = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seg_bcd_counter_if #(.DIGITS(2)) ifa ();
    seg_bcd_counter_if #(.DIGITS(6)) ifb ();

    seg_bcd_counter #(.TICK_DIV(4), .DIGITS(2), .MAX_BCD(8'h59), .BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    seg_bcd_counter #(.TICK_DIV(1), .DIGITS(6), .MAX_BCD(24'h123456), .BLANK_LZ(1'b1)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [23:0] int2bcd(input int v, input int digits);
        logic [23:0] b = '0;
        for (int i = 0; i < digits; i++) b[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return b;
    endfunction

    function automatic logic [41:0] exp_seg(input int v, input int digits, input bit blz);
        logic [41:0] s = '0;
        for (int i = 0; i < digits; i++) begin
            if (i > 0 && blz && v < pow10(i)) s[7*i +: 7] = 7'b1111111;
            else                              s[7*i +: 7] = seg_tab[(v / pow10(i)) % 10];
        end
        return s;
    endfunction

    // Count value kept as a plain decimal integer; load/step rules applied arithmetically.
    function automatic void model_step(input int digits, input int td, input int maxv,
                                       input bit r, input bit e, input bit u, input bit c, input bit l,
                                       input logic [23:0] lv, input int val, input int pc,
                                       output int nval, output int npc, output bit t, output bit w);
        nval = val; npc = pc; t = 1'b0; w = 1'b0;
        if (r || c) begin
            nval = 0; npc = 0;
        end else if (l) begin
            int s = 0;
            for (int i = 0; i < digits; i++) begin
                int d = int'(lv[4*i +: 4]);
                if (d > 9) d = 9;
                s = s + d * pow10(i);
            end
            npc  = 0;
            nval = (s > maxv) ? maxv : s;
        end else if (e) begin
            if (pc == td - 1) begin
                npc = 0; t = 1'b1;
                if (u) begin
                    if (val == maxv) begin nval = 0; w = 1'b1; end
                    else nval = val + 1;
                end else begin
                    if (val == 0) begin nval = maxv; w = 1'b1; end
                    else nval = val - 1;
                end
            end else begin
                npc = pc + 1;
            end
        end
    endfunction

    int ma_val = 0, ma_pc = 0, mb_val = 0, mb_pc = 0;
    bit ma_tk = 0, ma_wr = 0, mb_tk = 0, mb_wr = 0;

    always @(posedge clk) begin : model_a
        int v, p; bit t, w;
        model_step(2, 4, 59, rst, ifa.en, ifa.up_dn, ifa.clear, ifa.load, 24'(ifa.load_val),
                   ma_val, ma_pc, v, p, t, w);
        ma_val <= v; ma_pc <= p; ma_tk <= t; ma_wr <= w;
    end

    always @(posedge clk) begin : model_b
        int v, p; bit t, w;
        model_step(6, 1, 123456, rst, ifb.en, ifb.up_dn, ifb.clear, ifb.load, ifb.load_val,
                   mb_val, mb_pc, v, p, t, w);
        mb_val <= v; mb_pc <= p; mb_tk <= t; mb_wr <= w;
    end

    task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("A.bcd",  42'(ifa.bcd),  42'(int2bcd(ma_val, 2)));
            check("A.seg",  42'(ifa.seg),  exp_seg(ma_val, 2, 1'b1));
            check("A.tick", 42'(ifa.tick), 42'(ma_tk));
            check("A.wrap", 42'(ifa.wrap), 42'(ma_wr));
            check("B.bcd",  42'(ifb.bcd),  42'(int2bcd(mb_val, 6)));
            check("B.seg",  42'(ifb.seg),  exp_seg(mb_val, 6, 1'b1));
            check("B.tick", 42'(ifb.tick), 42'(mb_tk));
            check("B.wrap", 42'(ifb.wrap), 42'(mb_wr));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        ifa.en = 0; ifa.up_dn = 1; ifa.clear = 0; ifa.load = 0; ifa.load_val = '0;
        ifb.en = 0; ifb.up_dn = 1; ifb.clear = 0; ifb.load = 0; ifb.load_val = '0;
        cyc(2);
        armed = 1'b1;
        check("A.rst bcd", 42'(ifa.bcd), 42'(8'h00));
        check("A.rst seg", 42'(ifa.seg), 42'({7'b1111111, 7'b1000000}));
        check("A.rst tick/wrap", 42'({ifa.tick, ifa.wrap}), 42'(2'b00));

        rst = 0; ifa.en = 1; ifa.up_dn = 1;
        cyc(3);  check("A.up pre-step", 42'(ifa.bcd), 42'(8'h00));
        cyc(1);  check("A.up 4th edge", 42'(ifa.bcd), 42'(8'h01));
                 check("A.up tick", 42'(ifa.tick), 42'(1'b1));
        cyc(1);  check("A.tick one cycle", 42'(ifa.tick), 42'(1'b0));
        cyc(235);
        check("A.60 steps bcd", 42'(ifa.bcd), 42'(8'h00));
        check("A.60 steps wrap", 42'(ifa.wrap), 42'(1'b1));
        cyc(1);  check("A.wrap one cycle", 42'(ifa.wrap), 42'(1'b0));
        $display("[TB] A up-count and wrap phase done");

        rst = 1; cyc(1); rst = 0; ifa.up_dn = 0;
        cyc(4);
        check("A.down wrap bcd", 42'(ifa.bcd), 42'(8'h59));
        check("A.down wrap", 42'(ifa.wrap), 42'(1'b1));
        check("A.down seg", 42'(ifa.seg), 42'({7'b0010010, 7'b0010000}));
        cyc(4);  check("A.down next", 42'(ifa.bcd), 42'(8'h58));
        $display("[TB] A down-count phase done");

        ifa.load = 1; ifa.load_val = 8'h7A; cyc(1);
        check("A.load clamp", 42'(ifa.bcd), 42'(8'h59));
        check("A.load no tick", 42'(ifa.tick), 42'(1'b0));
        ifa.load_val = 8'h09; cyc(1);
        check("A.load 09", 42'(ifa.bcd), 42'(8'h09));
        check("A.load 09 seg", 42'(ifa.seg), 42'({7'b1111111, 7'b0010000}));
        ifa.load = 0; ifa.up_dn = 1;
        cyc(3);  check("A.pre-coincident", 42'(ifa.bcd), 42'(8'h09));
        ifa.load = 1; ifa.load_val = 8'h30; cyc(1);
        check("A.coincident load", 42'(ifa.bcd), 42'(8'h30));
        check("A.coincident tick/wrap", 42'({ifa.tick, ifa.wrap}), 42'(2'b00));
        ifa.load = 0;
        cyc(3);  check("A.restart hold", 42'(ifa.bcd), 42'(8'h30));
        cyc(1);  check("A.restart step", 42'(ifa.bcd), 42'(8'h31));
        ifa.clear = 1; cyc(1); ifa.clear = 0;
        check("A.clear", 42'({ifa.bcd, ifa.tick, ifa.wrap}), 42'(10'h000));
        $display("[TB] A load/clear phase done");

        ifa.load = 1; ifa.load_val = 8'h41; cyc(1); ifa.load = 0;
        cyc(4);  check("A.reach 42", 42'(ifa.bcd), 42'(8'h42));
        cyc(2);  ifa.en = 0;
        cyc(10); check("A.en=0 hold", 42'(ifa.bcd), 42'(8'h42));
        ifa.en = 1;
        cyc(1);  check("A.pcnt held", 42'(ifa.bcd), 42'(8'h42));
        cyc(1);  check("A.resume step", 42'(ifa.bcd), 42'(8'h43));
        ifa.load = 1; ifa.load_val = 8'h42; cyc(1); ifa.load = 0;
        cyc(2);
        rst = 1; cyc(1);
        check("A.rst mid bcd", 42'(ifa.bcd), 42'(8'h00));
        check("A.rst mid tick/wrap", 42'({ifa.tick, ifa.wrap}), 42'(2'b00));
        check("A.rst mid seg", 42'(ifa.seg), 42'({7'b1111111, 7'b1000000}));
        rst = 0;
        cyc(3);  check("A.post-rst hold", 42'(ifa.bcd), 42'(8'h00));
        cyc(1);  check("A.post-rst step", 42'(ifa.bcd), 42'(8'h01));
        ifa.en = 0;
        $display("[TB] A hold/reset phase done");

        ifb.load = 1; ifb.load_val = 24'h099999; cyc(1); ifb.load = 0;
        check("B.load 099999", 42'(ifb.bcd), 42'(24'h099999));
        ifb.en = 1; ifb.up_dn = 1; cyc(1);
        check("B.carry chain", 42'(ifb.bcd), 42'(24'h100000));
        check("B.carry seg", 42'(ifb.seg), 42'({7'b1111001, {5{7'b1000000}}}));
        ifb.load = 1; ifb.load_val = 24'h999999; cyc(1); ifb.load = 0;
        check("B.load over max", 42'(ifb.bcd), 42'(24'h123456));
        cyc(1);
        check("B.up wrap", 42'({ifb.bcd, ifb.wrap}), 42'({24'h000000, 1'b1}));
        check("B.zero seg", 42'(ifb.seg), 42'({{5{7'b1111111}}, 7'b1000000}));
        ifb.up_dn = 0; cyc(1);
        check("B.down wrap", 42'({ifb.bcd, ifb.wrap}), 42'({24'h123456, 1'b1}));
        $display("[TB] B carry/clamp phase done");

        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            ifa.en    = ($urandom_range(0, 9) != 0);
            ifa.clear = ($urandom_range(0, 79) == 0);
            ifa.load  = ($urandom_range(0, 39) == 0);
            ifa.load_val = 8'($urandom);
            if ($urandom_range(0, 49) == 0) ifa.up_dn = ~ifa.up_dn;
            ifb.en    = ($urandom_range(0, 5) != 0);
            ifb.clear = ($urandom_range(0, 199) == 0);
            ifb.load  = ($urandom_range(0, 29) == 0);
            for (int d = 0; d < 6; d++) ifb.load_val[4*d +: 4] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) ifb.up_dn = ~ifb.up_dn;
            cyc(1);
        end
        $display("[TB] random phase done");

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
